or_bus_master: RTL and testbench

Bus-side master that sits directly upstream of the OR-combiner register block (`dut`) and drives its write/read port. It accepts an operand pair (a, b) on a valid/ready stream and writes a to address 4 and b to address 5, each only after polling the matching FIFO-not-full flag. It then polls the result-valid flag, pops the result from address 3 and returns it on an output valid/ready stream. It is the single master of that bus: it is the only block writing a_ff/b_ff and the only block reading y_ff.

---
 rtl/or_bus_master_if.sv | 36 +++
 rtl/or_bus_master.sv | 138 +++++++++++++
 tb/tb_or_bus_master.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/or_bus_master_if.sv
// or_bus_master_if: operand stream, result stream and dut register bus.
// master = or_bus_master side; slave = environment/dut side.
interface or_bus_master_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_err;
   logic [2:0] write_address;
   logic [7:0] write_data;
   logic       write_en;
   logic       write_rdy;
   logic [2:0] read_address;
   logic       read_en;
   logic [7:0] read_data;
   logic       read_rdy;

   modport master (
      input  in_valid, in_a, in_b, out_ready,
      input  write_rdy, read_data, read_rdy,
      output in_ready, out_valid, out_data, out_err,
      output write_address, write_data, write_en,
      output read_address, read_en
   );

   modport slave (
      output in_valid, in_a, in_b, out_ready,
      output write_rdy, read_data, read_rdy,
      input  in_ready, out_valid, out_data, out_err,
      input  write_address, write_data, write_en,
      input  read_address, read_en
   );
endinterface

// File: rtl/or_bus_master.sv
// or_bus_master: sole bus master of the OR-combiner; writes a/b, pops y.
// Ports: CLK, RST_N (async, active-high), bus (or_bus_master_if.master).
// Option: OR_MASTER_CHECK_EN compares the popped result with a|b.
module or_bus_master #(
   parameter int TIMEOUT = 511,
   parameter int TO_W    = 10
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   or_bus_master_if.master       bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_POLL_A, S_WR_A, S_POLL_B,
      S_WR_B, S_POLL_Y, S_RD_Y, S_RESP
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t          state;
   state_t          state_nx;
   logic [7:0]      a_q;
   logic [7:0]      b_q;
   logic [7:0]      res_q;
   logic            err_q;
   logic [TO_W-1:0] cnt_q;
   logic            hit;
   logic            chk_err;
   logic            to_hit;

   // Flag polls look only at bit 0 of the returned register.
   assign hit = bus.read_rdy & bus.read_data[0];
   assign to_hit = (cnt_q == TO_LAST);

`ifdef OR_MASTER_CHECK_EN
   assign chk_err = (bus.read_data != (a_q | b_q));
`else
   assign chk_err = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RST_N) begin
      if (RST_N) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:   if (bus.in_valid) state_nx = S_POLL_A;
         S_POLL_A: if (hit) state_nx = S_WR_A;
         S_WR_A:   if (bus.write_rdy) state_nx = S_POLL_B;
         S_POLL_B: if (hit) state_nx = S_WR_B;
         S_WR_B:   if (bus.write_rdy) state_nx = S_POLL_Y;
         S_POLL_Y: begin
            // A hit in the last allowed cycle still wins.
            if (hit)         state_nx = S_RD_Y;
            else if (to_hit) state_nx = S_RESP;
         end
         S_RD_Y:   if (bus.read_rdy) state_nx = S_RESP;
         S_RESP:   if (bus.out_ready) state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready      = 1'b0;
      bus.out_valid     = 1'b0;
      bus.out_data      = 8'h00;
      bus.out_err       = 1'b0;
      bus.write_address = 3'd0;
      bus.write_data    = 8'h00;
      bus.write_en      = 1'b0;
      bus.read_address  = 3'd0;
      bus.read_en       = 1'b0;
      unique case (state)
         S_IDLE:   bus.in_ready = 1'b1;
         S_POLL_A: begin
            bus.read_address = 3'd0;
            bus.read_en      = 1'b1;
         end
         S_WR_A: begin
            bus.write_address = 3'd4;
            bus.write_data    = a_q;
            bus.write_en      = 1'b1;
         end
         S_POLL_B: begin
            bus.read_address = 3'd1;
            bus.read_en      = 1'b1;
         end
         S_WR_B: begin
            bus.write_address = 3'd5;
            bus.write_data    = b_q;
            bus.write_en      = 1'b1;
         end
         S_POLL_Y: begin
            bus.read_address = 3'd2;
            bus.read_en      = 1'b1;
         end
         S_RD_Y: begin
            bus.read_address = 3'd3;
            bus.read_en      = 1'b1;
         end
         S_RESP: begin
            bus.out_valid = 1'b1;
            bus.out_data  = res_q;
            bus.out_err   = err_q;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST_N) begin
      if (RST_N) begin
         a_q   <= 8'h00;
         b_q   <= 8'h00;
         res_q <= 8'h00;
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         if (state == S_IDLE && bus.in_valid) begin
            a_q <= bus.in_a;
            b_q <= bus.in_b;
         end
         if (state == S_WR_B)
            cnt_q <= '0;
         else if (state == S_POLL_Y)
            cnt_q <= cnt_q + TO_W'(1);
         if (state == S_POLL_Y && !hit && to_hit) begin
            res_q <= 8'h00;
            err_q <= 1'b1;
         end
         // On a check mismatch the captured value is passed through as-is.
         if (state == S_RD_Y && bus.read_rdy) begin
            res_q <= bus.read_data;
            err_q <= chk_err;
         end
      end
   end

endmodule

// File: tb/tb_or_bus_master.sv
// tb_or_bus_master: directed bench with a behavioural register-bus model.
// Ports: none; drives or_bus_master through or_bus_master_if.
module tb_or_bus_master;

   logic CLK = 1'b0;
   logic RST_N;
   int   total = 0;
   int   bad   = 0;

   or_bus_master_if bus ();

   or_bus_master #(.TIMEOUT(20), .TO_W(10)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   logic       nf_a;
   logic       nf_b;
   logic       yv;
   logic       y_force;
   logic [7:0] y_force_val;
   logic [7:0] wa_data = 8'h00;
   logic [7:0] wb_data = 8'h00;
   int         n_wa = 0;
   int         n_wb = 0;
   int         n_rd3 = 0;
   int         n_viol = 0;

   always_comb begin
      bus.read_data = 8'h00;
      case (bus.read_address)
         3'd0: bus.read_data = {7'b0, nf_a};
         3'd1: bus.read_data = {7'b0, nf_b};
         3'd2: bus.read_data = {7'b0, yv};
         3'd3: bus.read_data = y_force ? y_force_val : (wa_data | wb_data);
         default: bus.read_data = 8'h00;
      endcase
   end

   always @(posedge CLK) begin
      if (bus.write_en && bus.write_rdy && bus.write_address == 3'd4) begin
         n_wa    <= n_wa + 1;
         wa_data <= bus.write_data;
         if (!nf_a) n_viol <= n_viol + 1;
      end
      if (bus.write_en && bus.write_rdy && bus.write_address == 3'd5) begin
         n_wb    <= n_wb + 1;
         wb_data <= bus.write_data;
         if (!nf_b) n_viol <= n_viol + 1;
      end
      if (bus.read_en && bus.read_address == 3'd3) n_rd3 <= n_rd3 + 1;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!bus.out_valid && n < 400) begin
         tick();
         n++;
      end
      check("out_valid_seen", {31'b0, bus.out_valid}, 32'd1);
   endtask

   task automatic wait_poll_y(output int n);
      n = 0;
      while (!(bus.read_en && bus.read_address == 3'd2) && n < 100) begin
         tick();
         n++;
      end
      check("poll_y_seen", {31'b0, bus.read_en}, 32'd1);
   endtask

   task automatic start(input logic [7:0] a, input logic [7:0] b);
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      int  n;
      int  b_wa;
      int  b_wb;
      int  b_rd3;
      int  bad_cnt;
      logic [7:0] d0;

      RST_N         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = 8'h00;
      bus.in_b      = 8'h00;
      bus.out_ready = 1'b0;
      bus.write_rdy = 1'b1;
      bus.read_rdy  = 1'b1;
      nf_a = 1'b1;
      nf_b = 1'b1;
      yv   = 1'b0;
      y_force     = 1'b0;
      y_force_val = 8'h00;
      tick();
      tick();

      check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("rst_out_data", {24'b0, bus.out_data}, 32'd0);
      check("rst_out_err", {31'b0, bus.out_err}, 32'd0);
      check("rst_bus", {16'b0, bus.write_en, bus.write_address,
            bus.write_data, bus.read_en, bus.read_address}, 32'd0);
      RST_N = 1'b0;
      tick();

      // basic transaction, 7-cycle best-case latency
      yv = 1'b1;
      bus.out_ready = 1'b1;
      b_wa = n_wa;
      b_wb = n_wb;
      start(8'h0F, 8'hF0);
      wait_out(n);
      check("t1_latency", n + 1, 32'd7);
      check("t1_data", {24'b0, bus.out_data}, 32'hFF);
      check("t1_err", {31'b0, bus.out_err}, 32'd0);
      check("t1_n_wa", n_wa - b_wa, 32'd1);
      check("t1_n_wb", n_wb - b_wb, 32'd1);
      check("t1_wa_data", {24'b0, wa_data}, 32'h0F);
      check("t1_wb_data", {24'b0, wb_data}, 32'hF0);
      tick();
      check("t1_in_ready_back", {31'b0, bus.in_ready}, 32'd1);

      // address 0 reports full for 5 cycles
      nf_a = 1'b0;
      start(8'h11, 8'h22);
      bad_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.write_en) bad_cnt++;
         tick();
      end
      check("t2_no_write_while_full", bad_cnt, 32'd0);
      nf_a = 1'b1;
      tick();
      check("t2_write_en", {31'b0, bus.write_en}, 32'd1);
      check("t2_write_addr", {29'b0, bus.write_address}, 32'd4);
      check("t2_write_data", {24'b0, bus.write_data}, 32'h11);

      // hold out_ready low for 10 cycles
      bus.out_ready = 1'b0;
      wait_out(n);
      d0 = bus.out_data;
      check("t3_data", {24'b0, d0}, 32'h33);
      bad_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!bus.out_valid || bus.out_data != 8'h33 || bus.out_err ||
             bus.in_ready) bad_cnt++;
      end
      check("t3_stable", bad_cnt, 32'd0);
      bus.out_ready = 1'b1;
      tick();
      check("t3_released", {30'b0, bus.out_valid, bus.in_ready}, 32'd1);

      // timeout: address 2 never set
      yv = 1'b0;
      b_rd3 = n_rd3;
      start(8'h05, 8'h0A);
      wait_poll_y(n);
      wait_out(n);
      check("t4_poll_cycles", n, 32'd20);
      check("t4_err", {31'b0, bus.out_err}, 32'd1);
      check("t4_data", {24'b0, bus.out_data}, 32'h00);
      check("t4_no_rd3", n_rd3 - b_rd3, 32'd0);
      tick();

      // reset pulse while polling y
      start(8'h07, 8'h08);
      wait_poll_y(n);
      tick();
      tick();
      RST_N = 1'b1;
      #1;
      check("t5_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      check("t5_rst_bus", {16'b0, bus.write_en, bus.write_address,
            bus.write_data, bus.read_en, bus.read_address}, 32'd0);
      check("t5_rst_out", {22'b0, bus.out_valid, bus.out_err,
            bus.out_data}, 32'd0);
      #2;
      RST_N = 1'b0;
      tick();
      yv = 1'b1;
      start(8'h01, 8'h02);
      wait_out(n);
      check("t5_data", {24'b0, bus.out_data}, 32'h03);
      check("t5_err", {31'b0, bus.out_err}, 32'd0);
      tick();

      // wrong value at address 3
      y_force     = 1'b1;
      y_force_val = 8'h00;
      start(8'h01, 8'h02);
      wait_out(n);
      check("t6_data", {24'b0, bus.out_data}, 32'h00);
`ifdef OR_MASTER_CHECK_EN
      check("t6_err", {31'b0, bus.out_err}, 32'd1);
`else
      check("t6_err", {31'b0, bus.out_err}, 32'd0);
`endif
      tick();
      y_force = 1'b0;

      check("no_write_when_full", n_viol, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
